// File: rtl/mmio_shadow_bank.sv
// Double-buffered MMIO channel registers: the processor writes a working bank, and a commit copies it to the shadow bank in vblank.
// Optional macro SHADOW_BANK_DIRTY_EN adds dirty_mask and copies only the channels written since the last copy.
module mmio_shadow_bank #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     commit_req,
  input  logic                     vblank,
  output logic                     commit_pending,
  output logic                     commit_done,
  output logic                     wr_err,
  output logic [NUM_CH*DATA_W-1:0] shadow_flat
`ifdef SHADOW_BANK_DIRTY_EN
  ,
  output logic [NUM_CH-1:0]        dirty_mask
`endif
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  state_t state, state_next;
  logic rearm, rearm_next;
  logic copy;

  logic [DATA_W-1:0] working [NUM_CH];
  logic [DATA_W-1:0] shadow  [NUM_CH];
  logic [NUM_CH-1:0] dirty;

  logic wr_valid, rd_valid;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign wr_valid = wr_en && ({1'b0, wr_addr} < NUM_CH_L);
  assign rd_valid = {1'b0, rd_addr} < NUM_CH_L;
  assign wr_idx   = wr_addr[IDX_W-1:0];
  assign rd_idx   = rd_addr[IDX_W-1:0];

  assign commit_pending = (state == ARMED) || ((state == HOLD) && rearm);

  // HOLD keeps a second request until vblank drops, so each window sees at most one copy.
  always_comb begin
    state_next = state;
    rearm_next = rearm;
    copy       = 1'b0;
    case (state)
      IDLE: begin
        if (commit_req) state_next = ARMED;
      end
      ARMED: begin
        if (vblank) begin
          copy       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!vblank) begin
          state_next = (rearm || commit_req) ? ARMED : IDLE;
          rearm_next = 1'b0;
        end else if (commit_req) begin
          rearm_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        rearm_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rearm       <= 1'b0;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
      rd_data     <= '0;
      dirty       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        working[k] <= '0;
        shadow[k]  <= '0;
      end
    end else begin
      state       <= state_next;
      rearm       <= rearm_next;
      commit_done <= copy;
      wr_err      <= wr_en && !wr_valid;

      // The copy reads working before this edge's write lands, so a same-cycle write waits for the next commit.
      if (copy) begin
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef SHADOW_BANK_DIRTY_EN
          if (dirty[k]) shadow[k] <= working[k];
`else
          shadow[k] <= working[k];
`endif
        end
        dirty <= '0;
      end

      if (wr_valid) begin
        working[wr_idx] <= wr_data;
        dirty[wr_idx]   <= 1'b1;
      end

      if (!rd_valid) rd_data <= '0;
      else if (wr_valid && (wr_idx == rd_idx)) rd_data <= wr_data;
      else rd_data <= working[rd_idx];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign shadow_flat[g*DATA_W +: DATA_W] = shadow[g];
  end

`ifdef SHADOW_BANK_DIRTY_EN
  assign dirty_mask = dirty;
`endif

endmodule

// File: tb/tb_mmio_shadow_bank.sv
// Self-checking bench for mmio_shadow_bank: a pending/window model compared every cycle plus literal pins.
// Build with +define+SHADOW_BANK_DIRTY_EN to cover the dirty-tracking variant.
module tb_mmio_shadow_bank;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int FLAT_W = NUM_CH * DATA_W;
`ifdef SHADOW_BANK_DIRTY_EN
  localparam bit DIRTY = 1'b1;
`else
  localparam bit DIRTY = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              commit_req;
  logic              vblank;
  logic              commit_pending;
  logic              commit_done;
  logic              wr_err;
  logic [FLAT_W-1:0] shadow_flat;
  logic [NUM_CH-1:0] dirty_mask;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;

  mmio_shadow_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .commit_req     (commit_req),
    .vblank         (vblank),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .wr_err         (wr_err),
    .shadow_flat    (shadow_flat)
`ifdef SHADOW_BANK_DIRTY_EN
    ,
    .dirty_mask     (dirty_mask)
`endif
  );

`ifndef SHADOW_BANK_DIRTY_EN
  assign dirty_mask = '0;
`endif

  always #5 clock = ~clock;

  // Model: a request stays pending until a vblank edge in a window that has not yet been used.
  logic [DATA_W-1:0] m_working [NUM_CH];
  logic [DATA_W-1:0] m_shadow  [NUM_CH];
  logic [NUM_CH-1:0] m_dirty;
  bit                m_pending, m_window_used, m_valid;
  logic [DATA_W-1:0] m_rd;
  bit                m_err, m_done;

  always @(posedge clock) begin
    bit do_copy;
    if (reset) begin
      foreach (m_working[k]) begin
        m_working[k] = '0;
        m_shadow[k]  = '0;
      end
      m_dirty = '0; m_pending = 0; m_window_used = 0;
      m_rd = '0; m_err = 0; m_done = 0; m_valid = 1;
    end else begin
      do_copy = m_pending && vblank && !m_window_used;
      if (do_copy) begin
        foreach (m_shadow[k]) if (!DIRTY || m_dirty[k]) m_shadow[k] = m_working[k];
        m_dirty = '0;
        m_pending = 0;
        m_window_used = 1;
      end else begin
        m_pending = m_pending || commit_req;
      end
      if (!vblank) m_window_used = 0;
      m_done = do_copy;
      m_err  = wr_en && (int'(wr_addr) >= NUM_CH);
      if (wr_en && int'(wr_addr) < NUM_CH) begin
        m_working[wr_addr] = wr_data;
        m_dirty[wr_addr]   = 1'b1;
      end
      m_rd = (int'(rd_addr) < NUM_CH) ? m_working[rd_addr] : '0;
    end
  end

  function automatic logic [FLAT_W-1:0] model_flat();
    logic [FLAT_W-1:0] f = '0;
    for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = m_shadow[k];
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [FLAT_W-1:0] actual,
                             input logic [FLAT_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (commit_done === 1'b1) done_count++;
    if (m_valid) begin
      checkOutput("model_rd_data", FLAT_W'(rd_data), FLAT_W'(m_rd));
      checkOutput("model_wr_err", FLAT_W'(wr_err), FLAT_W'(m_err));
      checkOutput("model_commit_done", FLAT_W'(commit_done), FLAT_W'(m_done));
      checkOutput("model_commit_pending", FLAT_W'(commit_pending), FLAT_W'(m_pending));
      checkOutput("model_shadow_flat", shadow_flat, model_flat());
      if (DIRTY) checkOutput("model_dirty_mask", FLAT_W'(dirty_mask), FLAT_W'(m_dirty));
    end
  end

  task automatic applyStimulus(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                               input logic creq, input logic vb);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = ra; commit_req = creq; vblank = vb;
    @(posedge clock);
    #2;
  endtask

  function automatic logic [FLAT_W-1:0] ch(input int k);
    return FLAT_W'(shadow_flat[k*DATA_W +: DATA_W]);
  endfunction

  initial begin
    int base;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_rd_data", FLAT_W'(rd_data), '0);
    checkOutput("reset_shadow", shadow_flat, '0);
    checkOutput("reset_pending", FLAT_W'(commit_pending), '0);
    checkOutput("reset_done", FLAT_W'(commit_done), '0);

    // Basic write, commit, copy two cycles later.
    applyStimulus(0, 1, 3, 32'h0000_00A5, 3, 0, 0);
    checkOutput("write_first_rd", FLAT_W'(rd_data), FLAT_W'(32'hA5));
    applyStimulus(0, 0, 0, 0, 3, 1, 0);
    checkOutput("armed_pending", FLAT_W'(commit_pending), 1);
    applyStimulus(0, 0, 0, 0, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 3, 0, 1);
    checkOutput("copy_ch3", ch(3), FLAT_W'(32'hA5));
    checkOutput("copy_done_pulse", FLAT_W'(commit_done), 1);
    applyStimulus(0, 0, 0, 0, 3, 0, 1);
    checkOutput("done_one_cycle", FLAT_W'(commit_done), 0);
    applyStimulus(0, 0, 0, 0, 3, 0, 0);

    // Out-of-range write.
    applyStimulus(0, 1, 9, 32'hDEAD_BEEF, 9, 0, 0);
    checkOutput("oor_wr_err", FLAT_W'(wr_err), 1);
    checkOutput("oor_rd_zero", FLAT_W'(rd_data), 0);
    applyStimulus(0, 0, 0, 0, 3, 0, 0);
    checkOutput("oor_err_cleared", FLAT_W'(wr_err), 0);
    checkOutput("oor_rd_ch3", FLAT_W'(rd_data), FLAT_W'(32'hA5));
    checkOutput("oor_shadow", shadow_flat, FLAT_W'(32'hA5) << (3*DATA_W));

    // Two commits in one window: one copy, the second after vblank cycles.
    applyStimulus(0, 1, 2, 32'h22, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 2, 1, 0);
    base = done_count;
    applyStimulus(0, 0, 0, 0, 2, 0, 1);
    applyStimulus(0, 0, 0, 0, 2, 1, 1);
    applyStimulus(0, 1, 2, 32'h33, 2, 0, 1);
    applyStimulus(0, 0, 0, 0, 2, 0, 1);
    checkOutput("win1_one_copy", FLAT_W'(done_count - base), 1);
    checkOutput("win1_rearm_pending", FLAT_W'(commit_pending), 1);
    checkOutput("win1_ch2", ch(2), FLAT_W'(32'h22));
    applyStimulus(0, 0, 0, 0, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 2, 0, 0);
    checkOutput("gap_no_copy", FLAT_W'(done_count - base), 1);
    checkOutput("gap_pending", FLAT_W'(commit_pending), 1);
    applyStimulus(0, 0, 0, 0, 2, 0, 1);
    applyStimulus(0, 0, 0, 0, 2, 0, 0);
    checkOutput("win2_second_copy", FLAT_W'(done_count - base), 2);
    checkOutput("win2_ch2", ch(2), FLAT_W'(32'h33));
    checkOutput("win2_idle", FLAT_W'(commit_pending), 0);

    // Write during the copy cycle.
    applyStimulus(0, 1, 0, 32'h10, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h11, 0, 0, 1);
    checkOutput("copycycle_ch0_old", ch(0), FLAT_W'(32'h10));
    checkOutput("copycycle_rd_new", FLAT_W'(rd_data), FLAT_W'(32'h11));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("next_commit_ch0", ch(0), FLAT_W'(32'h11));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

`ifdef SHADOW_BANK_DIRTY_EN
    applyStimulus(0, 1, 1, 32'h1111, 1, 0, 0);
    applyStimulus(0, 1, 5, 32'h5555, 5, 0, 0);
    checkOutput("dirty_mask_22", FLAT_W'(dirty_mask), FLAT_W'(8'h22));
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("dirty_cleared", FLAT_W'(dirty_mask), 0);
    checkOutput("dirty_ch1", ch(1), FLAT_W'(32'h1111));
    checkOutput("dirty_ch5", ch(5), FLAT_W'(32'h5555));
    checkOutput("dirty_ch3_kept", ch(3), FLAT_W'(32'hA5));
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
`endif

    // Reset while ARMED, with a simultaneous write and vblank.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("pre_reset_armed", FLAT_W'(commit_pending), 1);
    applyStimulus(1, 1, 4, 32'hCAFE, 4, 1, 1);
    checkOutput("rst_rd_data", FLAT_W'(rd_data), 0);
    checkOutput("rst_shadow", shadow_flat, '0);
    checkOutput("rst_pending", FLAT_W'(commit_pending), 0);
    checkOutput("rst_done", FLAT_W'(commit_done), 0);
    applyStimulus(0, 0, 0, 0, 4, 0, 1);
    applyStimulus(0, 0, 0, 0, 4, 0, 1);
    checkOutput("post_rst_no_done", FLAT_W'(commit_done), 0);
    checkOutput("post_rst_shadow", shadow_flat, '0);
    checkOutput("post_rst_rd", FLAT_W'(rd_data), 0);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
